dmem_ctrl: RTL

Load/store sequencer between the core's data-memory port and the single-port 256 x 32 block RAM (`blk_mem_gen_0`: `ena`, single-bit `wea`, 1-cycle read latency). It accepts byte-addressed RV32I loads and stores (`lb`/`lbu`/`lh`/`lhu`/`lw`/`sb`/`sh`/`sw`) over a valid/ready handshake. It checks alignment and performs read-modify-write for sub-word stores, because the RAM has no byte enables. It returns sign- or zero-extended load data.

---
 rtl/dmem_ctrl_if.sv | 26 ++
 rtl/dmem_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the core's data-memory port and dmem_ctrl.
// The core is the master, dmem_ctrl is the slave.
interface dmem_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// RV32I load/store sequencer in front of a single-port 32-bit block RAM without
// byte enables: alignment checks, read-modify-write for sub-word stores, load extension.
module dmem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    dmem_ctrl_if.slave        bus,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);
    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

    state_t            state_reg, state_next;
    logic              we_reg;
    logic [1:0]        size_reg;
    logic              uns_reg;
    logic [ADDR_W+1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       data_reg;
    logic              err_reg;
    logic              req_err;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [31:0]       load_data;
    logic [7:0]        rd_lane [4];
    logic [7:0]        wr_lane [4];
    logic [3:0]        lane_sel;

    always_comb begin
        case (bus.req_size)
            2'd0:    req_err = 1'b0;
            2'd1:    req_err = bus.req_addr[0];
            2'd2:    req_err = |bus.req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            size_reg  <= 2'd0;
            uns_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= 32'd0;
            data_reg  <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && bus.req_valid) begin
                we_reg    <= bus.req_we;
                size_reg  <= bus.req_size;
                uns_reg   <= bus.req_unsigned;
                addr_reg  <= bus.req_addr;
                wdata_reg <= bus.req_wdata;
                err_reg   <= req_err;
            end
            if (state_reg == RD_WAIT) begin
                data_reg <= ram_dout;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err)
                        state_next = RESP;
                    else if (bus.req_we && bus.req_size == 2'd2)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD: begin
                ram_en     = 1'b1;
                state_next = RD_WAIT;
            end
            RD_WAIT: state_next = we_reg ? WR : RESP;
            WR: begin
                ram_en     = 1'b1;
                ram_we     = 1'b1;
                state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.req_ready = (state_reg == IDLE) && !rst;
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_err   = (state_reg == RESP) && err_reg;
    assign ram_addr      = addr_reg[ADDR_W+1:2];

    // Per-lane view of the captured word, and the write lanes a store replaces.
    // A word store selects all four lanes, so stale data_reg never reaches the RAM.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_lane[gi]  = data_reg[8*gi +: 8];
        assign lane_sel[gi] = (size_reg == 2'd2)
                            || (size_reg == 2'd1 && addr_reg[1] == 1'(gi / 2))
                            || (size_reg == 2'd0 && addr_reg[1:0] == 2'(gi));
        assign wr_lane[gi]  = (size_reg == 2'd2) ? wdata_reg[8*gi +: 8]
                            : (size_reg == 2'd1) ? wdata_reg[8*(gi % 2) +: 8]
                            : wdata_reg[7:0];
        assign ram_din[8*gi +: 8] = lane_sel[gi] ? wr_lane[gi] : rd_lane[gi];
    end

    assign byte_val = rd_lane[addr_reg[1:0]];
    assign half_val = addr_reg[1] ? data_reg[31:16] : data_reg[15:0];

    always_comb begin
        case (size_reg)
            2'd0:    load_data = {{24{!uns_reg && byte_val[7]}}, byte_val};
            2'd1:    load_data = {{16{!uns_reg && half_val[15]}}, half_val};
            default: load_data = data_reg;
        endcase
    end

    assign bus.rsp_rdata = (state_reg == RESP && !we_reg && !err_reg) ? load_data : 32'd0;
endmodule
